union_word_unpacker: RTL and testbench
======================================

UNION_WORD_UNPACKER -- requirements
Module: union_word_unpacker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 0, SHALL set the idle cycles allowed between bytes of a partial word; 0 disables the timeout.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 in_valid  input  1  SHALL qualify in_byte.
REQ-005 in_ready  output  1  SHALL indicate the block accepts in_byte this cycle.
REQ-006 in_byte  input  8  SHALL be a serial byte, MSB-first within the word.
REQ-007 out_valid  output  1  SHALL indicate a complete word is presented.
REQ-008 out_ready  input  1  SHALL be consumer acceptance.
REQ-009 out_word  output  32  SHALL be the raw view of the assembled union.
REQ-010 out_opcode / out_addr / out_data  output  4 / 12 / 16  SHALL be the struct view of the same storage: bits [31:28], [27:16], [15:0].
REQ-011 out_err  output  1  SHALL flag a checksum mismatch; valid with out_valid.
REQ-012 drop  output  1  SHALL pulse one cycle when a partial word is discarded by timeout.

Function
REQ-013 A byte SHALL transfer only when in_valid && in_ready.
REQ-014 Storage SHALL be one packed union word; the byte view SHALL be written and the raw and struct views read, with no separate copies.
REQ-015 State machine SHALL have states COLLECT, CHECK and HOLD; byte index 0..3 counts within COLLECT.
REQ-016 COLLECT: byte k SHALL be written to byte lane 3-k; after lane 0 is written, go to CHECK (macro on) or HOLD (macro off).
REQ-017 CHECK: in_ready=1; the next accepted byte SHALL be compared to the XOR of the four data bytes; go to HOLD.
REQ-018 HOLD: in_ready=0 and out_valid=1, with outputs stable until out_valid && out_ready; then go to COLLECT with index 0 on the next cycle.
REQ-019 Latency: out_valid SHALL rise the cycle after the final byte (data or checksum) transfers.
REQ-020 in_valid low in COLLECT/CHECK SHALL hold state; no bubble penalty.
REQ-021 Timeout (TIMEOUT_CYCLES>0): the idle counter SHALL clear on each accepted byte and count only while index>0 or in CHECK with in_valid low; on reaching TIMEOUT_CYCLES it SHALL pulse drop, clear index, and return to COLLECT. An accepted byte in the same cycle SHALL win.
REQ-022 HOLD SHALL never time out.

Reset
REQ-023 While rst_n=0: state=COLLECT, index=0, idle counter=0, word=32'h0, out_valid=0, out_err=0, drop=0, in_ready=1 after release.
REQ-024 Reset asserted mid-word or in HOLD SHALL discard the word with no drop pulse.

Configuration
REQ-025 With UNION_UNPACK_CHKSUM_EN defined, the CHECK state SHALL be compiled in and out_err SHALL follow REQ-017.
REQ-026 Without it, CHECK SHALL be absent, words SHALL be 4 bytes, and out_err SHALL be tied to 0.

Structure
REQ-027 Package union_unpack_pkg SHALL hold word_u (packed union of logic[31:0] raw, logic[3:0][7:0] bytes, and struct packed {opcode[3:0], addr[11:0], data[15:0]} fields), the state enum, and the constant BYTES_PER_WORD=4.
REQ-028 Idle counting SHALL be one sub-module, union_idle_timer (inputs clear and count enable; output expired).

Verification
REQ-029 Macro off; send bytes 8C,12,34,56 -> out_word=32'h8C123456, opcode=4'h8, addr=12'hC12, data=16'h3456, out_valid one cycle after the 4th byte.
REQ-030 out_ready low for 5 cycles in HOLD -> outputs stable, in_ready=0 throughout; out_ready=1 -> COLLECT next cycle.
REQ-031 Macro on; bytes 8C,12,34,56,FC -> out_err=0; same with FD -> out_err=1 and identical data fields.
REQ-032 TIMEOUT_CYCLES=3; send 2 bytes then idle -> drop pulses once on the 3rd idle cycle; the next 4 bytes assemble correctly.
REQ-033 Assert rst_n=0 after 3 bytes -> all outputs at reset values, no drop; a fresh 4-byte word decodes correctly.

Source files
------------

// File: rtl/union_unpack_pkg.sv
// ---------------------------------------------------------------------------
// union_unpack_pkg
// Shared types for the union word unpacker:
//   word_u         - one 32-bit packed union: raw, byte-lane and field views
//   state_e        - unpacker state encoding (CHECK only when checksum build)
//   BYTES_PER_WORD - data bytes per assembled word
//   xor_bytes()    - XOR of the four data byte lanes (checksum reference)
// Optional feature macro: UNION_UNPACK_CHKSUM_EN (adds the CHECK state).
// ---------------------------------------------------------------------------
package union_unpack_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] addr;
        logic [15:0] data;
    } fields_t;

    typedef union packed {
        logic [31:0]     raw;
        logic [3:0][7:0] bytes;
        fields_t         fields;
    } word_u;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
`ifdef UNION_UNPACK_CHKSUM_EN
        ST_CHECK   = 2'd2,
`endif
        ST_HOLD    = 2'd1
    } state_e;

    // Checksum reference: XOR across all four byte lanes.
    function automatic logic [7:0] xor_bytes(input word_u w);
        xor_bytes = w.bytes[3] ^ w.bytes[2] ^ w.bytes[1] ^ w.bytes[0];
    endfunction

endpackage

// File: rtl/union_idle_timer.sv
// ---------------------------------------------------------------------------
// union_idle_timer
// Counts idle cycles between bytes of a partial word.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart the count (a byte was accepted)
//   count_en   - this cycle is an idle cycle inside a partial word
//   expired    - this idle cycle is the TIMEOUT_CYCLES-th in a row
// TIMEOUT_CYCLES = 0 disables the timer (expired never asserts).
// ---------------------------------------------------------------------------
module union_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic        TIMER_ON = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Count value held during the last allowed idle cycle.
    localparam logic [CW-1:0] LAST   = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry is flagged during the idle cycle that completes the budget.
    assign expired = TIMER_ON && count_en && (cnt_q == LAST);

    // Next count: restart on clear or expiry, otherwise advance on idle cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = CW'(0);
        end else if (TIMER_ON && count_en) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Idle count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CW'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/union_word_unpacker.sv
// ---------------------------------------------------------------------------
// union_word_unpacker
// Assembles MSB-first serial bytes into one packed-union word and presents it
// through raw and field views with a valid/ready handshake.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   in_valid/in_ready/in_byte   - byte input handshake
//   out_valid/out_ready         - word output handshake
//   out_word                    - raw 32-bit view
//   out_opcode/out_addr/out_data- field view [31:28]/[27:16]/[15:0]
//   out_err                     - checksum mismatch (checksum build only)
//   drop                        - one-cycle pulse when a partial word times out
// Parameter TIMEOUT_CYCLES: idle cycles allowed inside a partial word (0=off).
// Optional feature macro: UNION_UNPACK_CHKSUM_EN - a fifth byte carrying the
// XOR of the four data bytes follows each word and sets out_err on mismatch.
// ---------------------------------------------------------------------------
module union_word_unpacker
    import union_unpack_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_opcode,
    output logic [11:0] out_addr,
    output logic [15:0] out_data,
    output logic        out_err,
    output logic        drop
);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    word_u      word_q, word_d;
    logic       drop_q, drop_d;
    logic       err_q, err_d;
    logic       accept_s;
    logic       count_en_s;
    logic       expired_s;

    assign in_ready   = (state_q != ST_HOLD);
    assign out_valid  = (state_q == ST_HOLD);
    assign accept_s   = in_valid && in_ready;
    assign out_word   = word_q.raw;
    assign out_opcode = word_q.fields.opcode;
    assign out_addr   = word_q.fields.addr;
    assign out_data   = word_q.fields.data;
    assign drop       = drop_q;
`ifdef UNION_UNPACK_CHKSUM_EN
    assign out_err    = err_q;
`else
    assign out_err    = 1'b0;
`endif

    // Idle cycles only matter while a word is partially collected.
    always_comb begin
        count_en_s = 1'b0;
`ifdef UNION_UNPACK_CHKSUM_EN
        if (((idx_q != 2'd0) || (state_q == ST_CHECK)) && !in_valid) begin
`else
        if ((idx_q != 2'd0) && !in_valid) begin
`endif
            count_en_s = 1'b1;
        end else begin
            count_en_s = 1'b0;
        end
    end

    union_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept_s),
        .count_en (count_en_s),
        .expired  (expired_s)
    );

    // Next-state, byte-lane write and status logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        err_d   = err_q;
        drop_d  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (accept_s) begin
                    // Byte k lands in lane 3-k so the first byte is the MSB.
                    word_d.bytes[2'd3 - idx_q] = in_byte;
                    if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
                        idx_d = 2'd0;
                        err_d = 1'b0;
`ifdef UNION_UNPACK_CHKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_HOLD;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (expired_s) begin
                    drop_d = 1'b1;
                    idx_d  = 2'd0;
                end else begin
                    idx_d = idx_q;
                end
            end
`ifdef UNION_UNPACK_CHKSUM_EN
            ST_CHECK: begin
                if (accept_s) begin
                    err_d   = (in_byte != xor_bytes(word_q));
                    state_d = ST_HOLD;
                end else if (expired_s) begin
                    drop_d  = 1'b1;
                    idx_d   = 2'd0;
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_COLLECT;
                    idx_d   = 2'd0;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State, index, word storage and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            idx_q      <= 2'd0;
            word_q.raw <= 32'h0000_0000;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_union_word_unpacker.sv
// ---------------------------------------------------------------------------
// tb_union_word_unpacker
// Directed self-checking bench for union_word_unpacker (TIMEOUT_CYCLES=3).
// Follows UNION_UNPACK_CHKSUM_EN: when defined a checksum byte follows each
// word. Inputs change 1 time unit after the rising edge; outputs are checked
// at that point or on the falling edge.
// ---------------------------------------------------------------------------
module tb_union_word_unpacker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [3:0]  out_opcode;
    logic [11:0] out_addr;
    logic [15:0] out_data;
    logic        out_err;
    logic        drop;

    int errors;
    int checks;

    union_word_unpacker #(
        .TIMEOUT_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_opcode (out_opcode),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_err    (out_err),
        .drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one byte for exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    // Four data bytes MSB first, plus the checksum byte in the checksum build.
    task automatic send_word(input logic [31:0] w, input logic [7:0] chk);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
`ifdef UNION_UNPACK_CHKSUM_EN
        send_byte(chk);
`else
        if (chk == 8'h00) begin
            in_byte = 8'h00;
        end
`endif
    endtask

    // Accept the held word with a single out_ready cycle.
    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_word !== 32'h0000_0000) begin errors++; $display("FAIL reset_out_word: got %h want 00000000", out_word); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        send_byte(8'h8C);
        send_byte(8'h12);
        send_byte(8'h34);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        send_byte(8'h56);
`ifdef UNION_UNPACK_CHKSUM_EN
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_before_chk: got %b want 0", out_valid); end
        send_byte(8'hFC);
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", out_err); end
`endif
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_latency: got %b want 1", out_valid); end
        checks++; if (out_word !== 32'h8C12_3456) begin errors++; $display("FAIL basic_word: got %h want 8c123456", out_word); end
        checks++; if (out_opcode !== 4'h8) begin errors++; $display("FAIL basic_opcode: got %h want 8", out_opcode); end
        checks++; if (out_addr !== 12'hC12) begin errors++; $display("FAIL basic_addr: got %h want c12", out_addr); end
        checks++; if (out_data !== 16'h3456) begin errors++; $display("FAIL basic_data: got %h want 3456", out_data); end
    endtask

    // Word from test_basic is still held; stall the consumer for 5 cycles.
    task automatic test_hold_stall();
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (out_word !== 32'h8C12_3456) begin errors++; $display("FAIL hold_word[%0d]: got %h want 8c123456", i, out_word); end
        end
        in_valid = 1'b0;
        in_byte  = 8'h00;
        @(posedge clk);
        #1;
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready: got %b want 1", in_ready); end
    endtask

`ifdef UNION_UNPACK_CHKSUM_EN
    task automatic test_checksum_bad();
        send_word(32'h8C12_3456, 8'hFD);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL chk_bad_valid: got %b want 1", out_valid); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL chk_bad_err: got %b want 1", out_err); end
        checks++; if (out_word !== 32'h8C12_3456) begin errors++; $display("FAIL chk_bad_word: got %h want 8c123456", out_word); end
        checks++; if (out_addr !== 12'hC12) begin errors++; $display("FAIL chk_bad_addr: got %h want c12", out_addr); end
        consume();
    endtask
`endif

    task automatic test_timeout();
        send_byte(8'hAA);
        send_byte(8'hBB);
        // Idle cycles 1 and 2: no drop yet.
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk);
            #1;
            checks++; if (drop !== 1'b0) begin errors++; $display("FAIL timeout_early_drop[%0d]: got %b want 0", i, drop); end
        end
        @(posedge clk);
        #1;
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL timeout_drop: got %b want 1", drop); end
        @(posedge clk);
        #1;
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL timeout_drop_width: got %b want 0", drop); end
        // 11^22^33^44 = 44
        send_word(32'h1122_3344, 8'h44);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL timeout_next_valid: got %b want 1", out_valid); end
        checks++; if (out_word !== 32'h1122_3344) begin errors++; $display("FAIL timeout_next_word: got %h want 11223344", out_word); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL timeout_next_err: got %b want 0", out_err); end
        consume();
    endtask

    task automatic test_back_to_back();
        // A0^B1^C2^D3 = 00 ; 1-cycle bubble inside word must not drop it.
        send_byte(8'hA0);
        send_byte(8'hB1);
        @(posedge clk);
        #1;
        send_byte(8'hC2);
        send_byte(8'hD3);
`ifdef UNION_UNPACK_CHKSUM_EN
        send_byte(8'h00);
`endif
        checks++; if (out_word !== 32'hA0B1_C2D3) begin errors++; $display("FAIL b2b_word1: got %h want a0b1c2d3", out_word); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL b2b_bubble_drop: got %b want 0", drop); end
        consume();
        // 01^23^45^67 = 00
        send_word(32'h0123_4567, 8'h00);
        checks++; if (out_word !== 32'h0123_4567) begin errors++; $display("FAIL b2b_word2: got %h want 01234567", out_word); end
        checks++; if (out_opcode !== 4'h0) begin errors++; $display("FAIL b2b_opcode2: got %h want 0", out_opcode); end
        checks++; if (out_addr !== 12'h123) begin errors++; $display("FAIL b2b_addr2: got %h want 123", out_addr); end
        consume();
    endtask

    task automatic test_reset_midword();
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h99);
        rst_n = 1'b0;
        #1;
        checks++; if (out_word !== 32'h0000_0000) begin errors++; $display("FAIL rstmid_word: got %h want 00000000", out_word); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rstmid_drop[%0d]: got %b want 0", i, drop); end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        // DE^AD^BE^EF = 22
        send_word(32'hDEAD_BEEF, 8'h22);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid: got %b want 1", out_valid); end
        checks++; if (out_word !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rstmid_new_word: got %h want deadbeef", out_word); end
        checks++; if (out_opcode !== 4'hD) begin errors++; $display("FAIL rstmid_new_opcode: got %h want d", out_opcode); end
        checks++; if (out_addr !== 12'hEAD) begin errors++; $display("FAIL rstmid_new_addr: got %h want ead", out_addr); end
        checks++; if (out_data !== 16'hBEEF) begin errors++; $display("FAIL rstmid_new_data: got %h want beef", out_data); end
        consume();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_hold_stall();
`ifdef UNION_UNPACK_CHKSUM_EN
        test_checksum_bad();
`endif
        test_timeout();
        test_back_to_back();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
